regfile: RTL

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile.sv | 113 +++++++++++
 2 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults and helpers for the register file.
//                Holds the default data width and register count, the
//                address-width derivation and the hard-wired zero
//                register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DATA_W_DEFAULT   = 16;
  localparam int NUM_REGS_DEFAULT = 8;
  localparam int ZERO_REG         = 0;

  // Index width for n registers. At least one bit, so a degenerate
  // one- or two-entry file still has a usable index port.
  function automatic int addr_w_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : Two-read / one-write register file with a hard-wired zero
//                register, overflow-qualified writes, a sticky overflow flag
//                and an 8-bit committed-write counter.
//  Optional    : REGFILE_BYPASS_EN - when defined, a read port addressing the
//                register being committed this cycle returns WriteData
//                combinationally.
//  Ports       : clk, rst_n (sync, active-low)
//                ReadReg1/ReadReg2 -> ReadData1/ReadData2 (combinational)
//                WriteReg, RegWrite, WriteData, Overflow - write port
//                ClearFlag     - clears OverflowFlag (a same-cycle set wins)
//                OverflowFlag  - sticky, set by any overflow-suppressed write
//                WriteCount    - committed writes, modulo 256
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEFAULT,
  parameter  int NUM_REGS = NUM_REGS_DEFAULT,
  localparam int ADDR_W   = addr_w_f(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              Overflow,
  input  logic              ClearFlag,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              OverflowFlag,
  output logic [7:0]        WriteCount
);

  // Register count expressed at index width plus one, so the range check
  // also works when NUM_REGS is an exact power of two.
  localparam logic [ADDR_W:0]   NUM_REGS_W = NUM_REGS[ADDR_W:0];
  localparam logic [ADDR_W-1:0] ZERO_IDX   = ZERO_REG[ADDR_W-1:0];

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              flag_q, flag_d;
  logic [7:0]        count_q, count_d;

  logic              w_commit;
  logic              w_suppress;
  logic [DATA_W-1:0] w_rd1_arr;
  logic [DATA_W-1:0] w_rd2_arr;

  // An index is live when it names a real, writable register.
  function automatic logic idx_live(input logic [ADDR_W-1:0] idx);
    return ({1'b0, idx} < NUM_REGS_W) && (idx != ZERO_IDX);
  endfunction

  assign w_commit   = RegWrite && !Overflow && idx_live(WriteReg);
  assign w_suppress = RegWrite && Overflow;

  always_comb begin
    flag_d  = flag_q;
    count_d = count_q;
    if (w_suppress) begin
      flag_d = 1'b1;            // set has priority over a same-cycle clear
    end else if (ClearFlag) begin
      flag_d = 1'b0;
    end
    if (w_commit) begin
      count_d = count_q + 8'd1; // wraps naturally at 8 bits
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      flag_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (w_commit) begin
        regs_q[WriteReg] <= WriteData;
      end
      flag_q  <= flag_d;
      count_q <= count_d;
    end
  end

  // Dead indices (zero register, out-of-range) read as zero regardless of
  // what the storage holds.
  assign w_rd1_arr = idx_live(ReadReg1) ? regs_q[ReadReg1] : '0;
  assign w_rd2_arr = idx_live(ReadReg2) ? regs_q[ReadReg2] : '0;

`ifdef REGFILE_BYPASS_EN
  // w_commit already excludes index 0, out-of-range and suppressed writes;
  // rst_n is added so nothing is forwarded while the file is being cleared.
  logic w_byp1, w_byp2;
  assign w_byp1    = w_commit && rst_n && (ReadReg1 == WriteReg);
  assign w_byp2    = w_commit && rst_n && (ReadReg2 == WriteReg);
  assign ReadData1 = w_byp1 ? WriteData : w_rd1_arr;
  assign ReadData2 = w_byp2 ? WriteData : w_rd2_arr;
`else
  assign ReadData1 = w_rd1_arr;
  assign ReadData2 = w_rd2_arr;
`endif

  assign OverflowFlag = flag_q;
  assign WriteCount   = count_q;

endmodule
`default_nettype wire
